// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// game_pkg : shared types and helpers for the board/cursor controller
// Rev 1.0
// ============================================================================
package game_pkg;

  localparam int BOARD_DIM_MAX = 16;

  typedef logic [4:0] cell_t;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Board dimension N = B*B for the supported block sizes.
  function automatic logic [4:0] board_dim(input logic [2:0] block);
    case (block)
      3'd2:    return 5'd4;
      3'd3:    return 5'd9;
      default: return 5'd16;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_autorepeat.sv
`default_nettype none
// ============================================================================
// key_autorepeat : direction-key arbitration with hold-to-repeat stepping
// Rev 1.0
// ============================================================================
module key_autorepeat
  import game_pkg::*;
#(
  parameter int REPEAT_DELAY  = 32_500_000,
  parameter int REPEAT_PERIOD = 6_500_000,
  parameter int CNT_W         = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic key_up,
  input  logic key_down,
  input  logic key_left,
  input  logic key_right,
  output logic step,
  output dir_t dir
);

  localparam logic [CNT_W-1:0] C_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] C_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  rpt_state_t       r_state, w_state_nxt;
  dir_t             r_dir, w_dir_win;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_any;

  always_comb begin
    w_any     = key_up | key_down | key_left | key_right;
    w_dir_win = DIR_RIGHT;
    if (key_up)        w_dir_win = DIR_UP;
    else if (key_down) w_dir_win = DIR_DOWN;
    else if (key_left) w_dir_win = DIR_LEFT;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    step        = 1'b0;
    if (!enable || !w_any) begin
      w_state_nxt = RPT_IDLE;
      w_cnt_nxt   = '0;
    end else if (r_state == RPT_IDLE || w_dir_win != r_dir) begin
      // Fresh press or a change of winning key restarts the long delay.
      step        = 1'b1;
      w_cnt_nxt   = '0;
      w_state_nxt = RPT_DELAY;
    end else begin
      case (r_state)
        RPT_DELAY: begin
          if (r_cnt == C_DELAY_LAST) begin
            step        = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = RPT_REPEAT;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (r_cnt == C_PERIOD_LAST) begin
            step      = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: w_state_nxt = RPT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RPT_IDLE;
      r_cnt   <= '0;
      r_dir   <= DIR_UP;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (enable && w_any) r_dir <= w_dir_win;
    end
  end

  assign dir = w_dir_win;

endmodule
`default_nettype wire

// File: rtl/game_board_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// game_board_cursor_ctrl : board cell store, selection cursor, filled count
// Rev 1.0
// ============================================================================
module game_board_cursor_ctrl
  import game_pkg::*;
#(
  parameter int REPEAT_DELAY  = 32_500_000,
  parameter int REPEAT_PERIOD = 6_500_000,
  parameter int CNT_W         = 25
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     is_game_on,
  input  logic [2:0]               board_size,
  input  logic                     key_up,
  input  logic                     key_down,
  input  logic                     key_left,
  input  logic                     key_right,
  input  logic                     digit_valid,
  input  logic [4:0]               digit,
  input  logic                     load_valid,
  input  logic [3:0]               load_x,
  input  logic [3:0]               load_y,
  input  logic [4:0]               load_value,
  input  logic                     load_fixed,
  output cell_t                    board       [BOARD_DIM_MAX][BOARD_DIM_MAX],
  output logic [BOARD_DIM_MAX-1:0] board_fixed [BOARD_DIM_MAX],
  output logic [3:0]               selection_x,
  output logic [3:0]               selection_y,
  output logic [8:0]               filled_count,
  output logic                     cell_written
);

  logic [4:0] w_dim;
  logic [3:0] w_last;
  logic       r_game_on_d;
  logic [2:0] r_size_d;
  logic       w_restart;
  logic       w_step;
  dir_t       w_dir;
  logic       w_load_ok, w_digit_ok, w_wr_en;
  logic [3:0] w_wr_x, w_wr_y;
  cell_t      w_wr_val, w_old_val;

  assign w_dim     = board_dim(board_size);
  assign w_last    = 4'(w_dim - 5'd1);
  assign w_restart = (is_game_on & ~r_game_on_d) | (board_size != r_size_d);

  key_autorepeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .CNT_W        (CNT_W)
  ) u_keys (
    .clk      (clk),
    .rst      (rst),
    .enable   (is_game_on & ~w_restart),
    .key_up   (key_up),
    .key_down (key_down),
    .key_left (key_left),
    .key_right(key_right),
    .step     (w_step),
    .dir      (w_dir)
  );

  // Single write port: a load always pre-empts a digit in the same cycle.
  always_comb begin
    w_load_ok  = load_valid && ({1'b0, load_x} < w_dim) && ({1'b0, load_y} < w_dim)
                 && (load_value <= w_dim);
    w_digit_ok = digit_valid && !load_valid && is_game_on
                 && !board_fixed[selection_y][selection_x] && (digit <= w_dim);
    w_wr_en    = w_load_ok | w_digit_ok;
    w_wr_x     = w_load_ok ? load_x : selection_x;
    w_wr_y     = w_load_ok ? load_y : selection_y;
    w_wr_val   = w_load_ok ? load_value : digit;
    w_old_val  = board[w_wr_y][w_wr_x];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      selection_x <= '0;
      selection_y <= '0;
      r_game_on_d <= is_game_on;
      r_size_d    <= board_size;
    end else begin
      r_game_on_d <= is_game_on;
      r_size_d    <= board_size;
      if (w_restart) begin
        selection_x <= '0;
        selection_y <= '0;
      end else if (w_step) begin
        case (w_dir)
          DIR_UP:    selection_y <= (selection_y == 4'd0) ? w_last : selection_y - 4'd1;
          DIR_DOWN:  selection_y <= (selection_y == w_last) ? 4'd0 : selection_y + 4'd1;
          DIR_LEFT:  selection_x <= (selection_x == 4'd0) ? w_last : selection_x - 4'd1;
          DIR_RIGHT: selection_x <= (selection_x == w_last) ? 4'd0 : selection_x + 4'd1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < BOARD_DIM_MAX; r++) begin
        for (int c = 0; c < BOARD_DIM_MAX; c++) board[r][c] <= '0;
        board_fixed[r] <= '0;
      end
      filled_count <= '0;
      cell_written <= 1'b0;
    end else begin
      cell_written <= w_digit_ok;
      if (w_wr_en) begin
        board[w_wr_y][w_wr_x] <= w_wr_val;
        if (w_load_ok) board_fixed[w_wr_y][w_wr_x] <= load_fixed;
        if (w_old_val == '0 && w_wr_val != '0)      filled_count <= filled_count + 9'd1;
        else if (w_old_val != '0 && w_wr_val == '0) filled_count <= filled_count - 9'd1;
      end
    end
  end

endmodule
`default_nettype wire
